// File: rtl/regfile_pkg.sv
// Shared defaults for the register file with an embedded program counter.
// Holds the default data/address widths, the PC step and reset value, and
// a helper that returns the register index used for the PC.
package regfile_pkg;

    localparam int DEF_DW       = 32;
    localparam int DEF_AW       = 4;
    localparam int DEF_NRD      = 2;
    localparam int DEF_PC_STEP  = 4;
    localparam int DEF_RESET_PC = 0;

    // The PC sits at the highest address of the register space.
    function automatic int pc_index(input int aw);
        return (2 ** aw) - 1;
    endfunction

endpackage

// File: rtl/pc_unit.sv
// Program counter for regfile_pc.
// Ports:
//   clk      in   clock, rising-edge
//   rst      in   synchronous active-high reset, loads RESET_PC
//   we       in   direct PC write (already qualified with the PC address)
//   wd       in   PC write value
//   ib       in   branch taken
//   bv       in   branch target
//   pc_stall in   hold the PC this cycle
//   pc_out   out  registered PC
// Next-value priority: reset, write, branch, stall, increment.
module pc_unit
    import regfile_pkg::*;
#(
    parameter int              DW       = DEF_DW,
    parameter int              PC_STEP  = DEF_PC_STEP,
    parameter logic [DW-1:0]   RESET_PC = DW'(DEF_RESET_PC)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [DW-1:0] wd,
    input  logic          ib,
    input  logic [DW-1:0] bv,
    input  logic          pc_stall,
    output logic [DW-1:0] pc_out
);

    logic [DW-1:0] pc_d;
    logic [DW-1:0] pc_q;

    // Addition is naturally modulo 2**DW, so the increment wraps past all-ones.
    always_comb begin
        pc_d = pc_q + DW'(PC_STEP);
        if (we) begin
            pc_d = wd;
        end else if (ib) begin
            pc_d = bv;
        end else if (pc_stall) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_out = pc_q;

endmodule

// File: rtl/regfile_pc.sv
// Register file of 2**AW entries whose top entry is the program counter.
// Ports:
//   clk      in   clock, rising-edge
//   rst      in   synchronous active-high reset: clears GPRs and read data,
//                 loads the PC with RESET_PC, discards same-cycle writes
//   rd_addr  in   NRD packed read addresses, port k at [k*AW +: AW]
//   rd_data  out  NRD packed registered read data, port k at [k*DW +: DW]
//   we/wa/wd in   write enable, address, data (address NREG-1 writes the PC)
//   ib/bv    in   branch taken and target
//   pc_stall in   hold the PC this cycle
//   pc_out   out  registered PC
// There is no handshake: every read port returns data one cycle after the
// address is sampled, every cycle.
module regfile_pc
    import regfile_pkg::*;
#(
    parameter int              DW       = DEF_DW,
    parameter int              AW       = DEF_AW,
    parameter int              NRD      = DEF_NRD,
    parameter int              PC_STEP  = DEF_PC_STEP,
    parameter logic [DW-1:0]   RESET_PC = DW'(DEF_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*DW-1:0] rd_data,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic [DW-1:0]     wd,
    input  logic              ib,
    input  logic [DW-1:0]     bv,
    input  logic              pc_stall,
    output logic [DW-1:0]     pc_out
);

    localparam int            NREG   = 2 ** AW;
    localparam int            NGPR   = NREG - 1;
    localparam logic [AW-1:0] PC_IDX = AW'(pc_index(AW));

    logic          pc_we;
    logic [DW-1:0] gpr_d [NGPR];
    logic [DW-1:0] gpr_q [NGPR];

    assign pc_we = we && (wa == PC_IDX);

    pc_unit #(
        .DW       (DW),
        .PC_STEP  (PC_STEP),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .we       (pc_we),
        .wd       (wd),
        .ib       (ib),
        .bv       (bv),
        .pc_stall (pc_stall),
        .pc_out   (pc_out)
    );

    // GPR storage only covers 0..NREG-2; the PC address never matches here.
    always_comb begin
        for (int i = 0; i < NGPR; i++) begin
            gpr_d[i] = (we && (wa == AW'(i))) ? wd : gpr_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NGPR; i++) begin
                gpr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NGPR; i++) begin
                gpr_q[i] <= gpr_d[i];
            end
        end
    end

    // One identical registered read lane per port.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] addr;
        logic [DW-1:0] rd_d;
        logic [DW-1:0] rd_q;

        assign addr = rd_addr[k*AW +: AW];

        // PC reads return the pre-edge PC (no forwarding of a PC write);
        // GPR reads forward a same-edge write so the new value is seen.
        always_comb begin
            rd_d = '0;
            if (addr == PC_IDX) begin
                rd_d = pc_out;
            end else if (we && (wa == addr)) begin
                rd_d = wd;
            end else begin
                for (int i = 0; i < NGPR; i++) begin
                    if (addr == AW'(i)) begin
                        rd_d = gpr_q[i];
                    end
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_q <= '0;
            end else begin
                rd_q <= rd_d;
            end
        end

        assign rd_data[k*DW +: DW] = rd_q;
    end

endmodule

// File: tb/tb_regfile_pc.sv
module tb_regfile_pc;

  typedef struct {
    int                due;
    int                dut;
    logic [3:0]        rd_m;
    logic [3:0][31:0]  rd_e;
    logic [31:0]       pc_e;
    string             name;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  // ---------------- DUT A: defaults ----------------
  logic        a_rst = 1'b1;
  logic [7:0]  a_rd_addr = '0;
  logic [63:0] a_rd_data;
  logic        a_we = 1'b0;
  logic [3:0]  a_wa = '0;
  logic [31:0] a_wd = '0;
  logic        a_ib = 1'b0;
  logic [31:0] a_bv = '0;
  logic        a_stall = 1'b0;
  logic [31:0] a_pc;

  regfile_pc u_dut_a (
    .clk      (clk),
    .rst      (a_rst),
    .rd_addr  (a_rd_addr),
    .rd_data  (a_rd_data),
    .we       (a_we),
    .wa       (a_wa),
    .wd       (a_wd),
    .ib       (a_ib),
    .bv       (a_bv),
    .pc_stall (a_stall),
    .pc_out   (a_pc)
  );

  // ---------------- DUT B: NRD=4, AW=3, DW=16 ----------------
  logic        b_rst = 1'b1;
  logic [11:0] b_rd_addr = '0;
  logic [63:0] b_rd_data;
  logic        b_we = 1'b0;
  logic [2:0]  b_wa = '0;
  logic [15:0] b_wd = '0;
  logic        b_ib = 1'b0;
  logic [15:0] b_bv = '0;
  logic        b_stall = 1'b0;
  logic [15:0] b_pc;

  regfile_pc #(
    .DW       (16),
    .AW       (3),
    .NRD      (4),
    .PC_STEP  (4),
    .RESET_PC (16'h0000)
  ) u_dut_b (
    .clk      (clk),
    .rst      (b_rst),
    .rd_addr  (b_rd_addr),
    .rd_data  (b_rd_data),
    .we       (b_we),
    .wa       (b_wa),
    .wd       (b_wd),
    .ib       (b_ib),
    .bv       (b_bv),
    .pc_stall (b_stall),
    .pc_out   (b_pc)
  );

  // ---------------- scoreboard ----------------
  exp_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string nm, input string field, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s %s: got %h expected %h", nm, field, got, want);
  endtask

  // Monitor: after each rising edge, compare every expectation due at that edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= edge_cnt) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.due < edge_cnt) begin
        check(e.name, "missed_sample", 32'd0, 32'd1);
      end else if (e.dut == 0) begin
        for (int k = 0; k < 2; k++)
          if (e.rd_m[k]) check(e.name, $sformatf("rd%0d", k), a_rd_data[k*32 +: 32], e.rd_e[k]);
        check(e.name, "pc", a_pc, e.pc_e);
      end else begin
        for (int k = 0; k < 4; k++)
          if (e.rd_m[k]) check(e.name, $sformatf("rd%0d", k), {16'h0, b_rd_data[k*16 +: 16]}, e.rd_e[k]);
        check(e.name, "pc", {16'h0, b_pc}, e.pc_e);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic cyc_a(input logic r, input logic w, input logic [3:0] wa, input logic [31:0] wd,
                       input logic ib, input logic [31:0] bv, input logic st,
                       input logic [3:0] a0, input logic [3:0] a1,
                       input logic m0, input logic [31:0] e0, input logic m1, input logic [31:0] e1,
                       input logic [31:0] epc, input string nm);
    exp_t e;
    @(negedge clk);
    a_rst = r; a_we = w; a_wa = wa; a_wd = wd; a_ib = ib; a_bv = bv; a_stall = st;
    a_rd_addr = {a1, a0};
    e.due = edge_cnt + 1; e.dut = 0; e.rd_m = {2'b00, m1, m0};
    e.rd_e = '0; e.rd_e[0] = e0; e.rd_e[1] = e1; e.pc_e = epc; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic cyc_b(input logic r, input logic w, input logic [2:0] wa, input logic [15:0] wd,
                       input logic [11:0] addr, input logic [3:0] m, input logic [63:0] ev,
                       input logic [15:0] epc, input string nm);
    exp_t e;
    @(negedge clk);
    b_rst = r; b_we = w; b_wa = wa; b_wd = wd; b_ib = 1'b0; b_bv = '0; b_stall = 1'b0;
    b_rd_addr = addr;
    e.due = edge_cnt + 1; e.dut = 1; e.rd_m = m;
    for (int k = 0; k < 4; k++) e.rd_e[k] = {16'h0, ev[k*16 +: 16]};
    e.pc_e = {16'h0, epc}; e.name = nm;
    exp_q.push_back(e);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    // reset, then all GPRs read back 0 on both ports while PC counts by 4
    cyc_a(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 32'h0, "reset");
    for (int i = 0; i < 15; i++)
      cyc_a(0, 0, 0, 0, 0, 0, 0, 4'(i), 4'(i), 1, 0, 1, 0, 32'(4 * (i + 1)), $sformatf("rd_zero_r%0d", i));

    // write forwarding, then later read on the other port
    cyc_a(0, 1, 3, 32'hDEADBEEF, 0, 0, 0, 3, 0, 1, 32'hDEADBEEF, 1, 0, 32'd64, "fwd_r3");
    cyc_a(0, 0, 0, 0, 0, 0, 0, 3, 3, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF, 32'd68, "read_r3_both");
    cyc_a(0, 1, 7, 32'h12345678, 0, 0, 0, 7, 15, 1, 32'h12345678, 1, 32'h44, 32'd72, "fwd_r7_rd_pc");

    // PC priority: write beats branch and stall; PC read sees pre-edge value
    cyc_a(0, 1, 15, 32'h100, 1, 32'h200, 1, 15, 3, 1, 32'h48, 1, 32'hDEADBEEF, 32'h100, "pc_write_prio");
    cyc_a(0, 0, 0, 0, 1, 32'h200, 0, 15, 7, 1, 32'h100, 1, 32'h12345678, 32'h200, "pc_branch");
    cyc_a(0, 1, 2, 32'hA5A5, 0, 0, 1, 3, 2, 1, 32'hDEADBEEF, 1, 32'hA5A5, 32'h200, "pc_stall_gpr_wr");
    cyc_a(0, 0, 0, 0, 0, 0, 0, 2, 15, 1, 32'hA5A5, 1, 32'h200, 32'h204, "pc_incr");
    cyc_a(0, 0, 0, 0, 1, 32'h300, 1, 0, 0, 1, 0, 1, 0, 32'h300, "branch_over_stall");

    // wrap at all-ones
    cyc_a(0, 1, 15, 32'hFFFFFFFC, 0, 0, 0, 15, 0, 1, 32'h300, 1, 0, 32'hFFFFFFFC, "pc_force_top");
    cyc_a(0, 0, 0, 0, 0, 0, 0, 15, 0, 1, 32'hFFFFFFFC, 0, 0, 32'h0, "pc_wrap");
    cyc_a(0, 0, 0, 0, 0, 0, 0, 1, 15, 1, 0, 1, 32'h0, 32'h4, "post_wrap");

    // reset mid-operation discards write, branch and stall
    cyc_a(1, 1, 5, 32'h55, 1, 32'h999, 1, 3, 2, 1, 0, 1, 0, 32'h0, "reset_midop");
    cyc_a(0, 0, 0, 0, 0, 0, 0, 5, 3, 1, 0, 1, 0, 32'h4, "after_reset_r5_r3");
    cyc_a(0, 1, 9, 32'hCAFE, 0, 0, 0, 2, 7, 1, 0, 1, 0, 32'h8, "after_reset_r2_r7");

    // persistence over idle cycles
    cyc_a(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'd12, "idle1");
    cyc_a(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'd16, "idle2");
    cyc_a(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'd20, "idle3");
    cyc_a(0, 0, 0, 0, 0, 0, 0, 9, 9, 1, 32'hCAFE, 1, 32'hCAFE, 32'd24, "persist_r9");

    // parameter sweep instance: NRD=4, AW=3, DW=16, PC at index 7
    cyc_b(1, 0, 0, 16'h0, 12'h000, 4'hF, 64'h0, 16'h0000, "b_reset");
    cyc_b(0, 1, 0, 16'h1111, 12'h000, 4'h0, 64'h0, 16'h0004, "b_wr_r0");
    cyc_b(0, 1, 1, 16'h2222, 12'h000, 4'h0, 64'h0, 16'h0008, "b_wr_r1");
    cyc_b(0, 1, 2, 16'h3333, 12'h000, 4'h0, 64'h0, 16'h000C, "b_wr_r2");
    cyc_b(0, 1, 3, 16'h4444, 12'h000, 4'h0, 64'h0, 16'h0010, "b_wr_r3");
    cyc_b(0, 0, 0, 16'h0, {3'd3, 3'd2, 3'd1, 3'd0}, 4'hF,
          {16'h4444, 16'h3333, 16'h2222, 16'h1111}, 16'h0014, "b_read_r0_r3");
    cyc_b(0, 0, 0, 16'h0, {3'd7, 3'd7, 3'd7, 3'd7}, 4'hF,
          {16'h0014, 16'h0014, 16'h0014, 16'h0014}, 16'h0018, "b_read_pc_all");
    cyc_b(0, 1, 7, 16'hFFFC, 12'h000, 4'h1, 64'h1111, 16'hFFFC, "b_pc_force_top");
    cyc_b(0, 0, 0, 16'h0, 12'h000, 4'h1, 64'h1111, 16'h0000, "b_pc_wrap");

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) check("drain", "pending", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_pc.md
REGFILE_PC -- requirements
Module: regfile_pc

Interface
REQ-001 The block SHALL take parameter DW, default 32: data width in bits.
REQ-002 The block SHALL take parameter AW, default 4: address width; NREG = 2**AW registers, index NREG-1 is the PC.
REQ-003 The block SHALL take parameter NRD, default 2: number of read ports, min 1, max 4.
REQ-004 The block SHALL take parameter PC_STEP, default 4: PC auto-increment amount.
REQ-005 The block SHALL take parameter RESET_PC, default 0: PC value after reset.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 rd_addr  in  NRD*AW  packed read addresses; port k uses bits [k*AW +: AW].
REQ-009 rd_data  out  NRD*DW  packed registered read data; port k uses bits [k*DW +: DW].
REQ-010 we  in  1  write enable.
REQ-011 wa  in  AW  write address.
REQ-012 wd  in  DW  write data.
REQ-013 ib  in  1  branch taken.
REQ-014 bv  in  DW  branch target.
REQ-015 pc_stall  in  1  hold PC this cycle.
REQ-016 pc_out  out  DW  current PC, registered.

Function
REQ-017 GPRs 0..NREG-2 SHALL be written on the clock edge where we=1 and wa!=NREG-1, with wd.
REQ-018 Each read port SHALL have 1-cycle latency: rd_data[k] after edge t reflects rd_addr[k] sampled at edge t.
REQ-019 Write-forwarding: if we=1 and wa==rd_addr[k]!=NREG-1 at the same edge, rd_data[k] SHALL take wd, not the old contents.
REQ-020 A read of address NREG-1 SHALL return pc_out as it was before the edge; no forwarding from a same-cycle PC write.
REQ-021 Multiple ports reading the same address SHALL all return identical data.
REQ-022 PC next-value priority at each edge: rst -> RESET_PC; else we=1 and wa==NREG-1 -> wd; else ib=1 -> bv; else pc_stall=1 -> hold; else pc_out+PC_STEP.
REQ-023 PC arithmetic SHALL be modulo 2**DW, so increment from all-ones minus PC_STEP-1 wraps without error.
REQ-024 pc_stall SHALL NOT block a PC write or a branch, and SHALL NOT affect GPR writes or reads.
REQ-025 Register contents SHALL persist indefinitely absent writes; there is no read side effect.

Reset
REQ-026 While rst=1 at an edge, all GPRs SHALL clear to 0, all rd_data lanes SHALL go to 0, and pc_out SHALL go to RESET_PC.
REQ-027 A write, branch or stall presented in a reset cycle SHALL be discarded.
REQ-028 On the first edge after rst deasserts, normal operation SHALL resume: reads return 0 (or forwarded wd), PC increments from RESET_PC.

Structure
REQ-029 Package regfile_pkg SHALL hold default constants for DW, AW, PC_STEP, RESET_PC and a PC-index function of AW.
REQ-030 PC logic SHALL be a separate sub-module pc_unit (ports: clk, rst, we, wd, ib, bv, pc_stall, pc_out); the top instantiates it once.
REQ-031 Read ports SHALL be produced by a generate loop over NRD; no port-specific hand-written logic.

Verification
REQ-032 Reset: rst=1 one edge, then read r0..r14 on both ports -> all 0; pc_out=0 after reset, 4 one edge later.
REQ-033 Forwarding: we=1, wa=3, wd=0xDEADBEEF, rd_addr0=3 same edge -> rd_data0=0xDEADBEEF next cycle; port1 reading r3 one cycle later -> 0xDEADBEEF.
REQ-034 PC priority: we=1, wa=15, wd=0x100, ib=1, bv=0x200, pc_stall=1 -> pc_out=0x100; next edge ib=1, bv=0x200 only -> 0x200; next edge pc_stall=1 -> holds 0x200; next edge idle -> 0x204.
REQ-035 Wrap: force PC to 0xFFFFFFFC via write to r15, idle edge -> pc_out=0x00000000.
REQ-036 Reset mid-op: we=1, wa=5, wd=0x55 with rst=1 same edge -> r5 reads 0 afterward; pc_out=RESET_PC.
REQ-037 Param sweep: NRD=4, AW=3, DW=16 -> four ports read r0..r3 after writes 0x1111..0x4444 and return them in order; PC index is 7.
